sprite_line_engine: RTL and testbench

SPRITE_LINE_ENGINE -- requirements
Module: sprite_line_engine

---
 rtl/sprite_line_engine.sv | 249 ++++++++++++++++++++++++
 tb/tb_sprite_line_engine.sv | 328 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sprite_line_engine.sv
// ---------------------------------------------------------------------------
// sprite_line_engine
//
// Per-scanline sprite compositor. While in LOAD (after a line_start pulse)
// up to NSPR sprite descriptors are captured into slots. During DRAW each
// slot starts when the beam position cx reaches its posx and then walks its
// 16 two-bit pixels, repeating each one scale+1 times, optionally mirrored.
// A two-stage pipeline resolves the final colour: UI overlay first, then the
// lowest-index opaque slot, then the background colour.
//
// Ports:
//   clk, rst          rising-edge clock, asynchronous active-high reset
//   line_start        hblank pulse: clears slots, enters LOAD
//   ld_valid/ld_ready descriptor handshake (ld_ready is combinational)
//   ld_posx, ld_pix, ld_pal, ld_scale, ld_mirror   descriptor fields
//   slot_mask         live per-slot output enable
//   pix_en, cx        one display pixel per pix_en cycle at position cx
//   bcgcol            background colour
//   ui_sel, ui_pal    UI overlay select and its palette
//   out_col/out_valid final colour, valid two cycles after pix_en
//   collision         sticky: two or more opaque slots on one pixel
//   overflow          sticky: descriptor offered with all slots full
//   ld_count          number of slots loaded this line
// ---------------------------------------------------------------------------
module sprite_line_engine #(
    parameter int NSPR = 8,
    parameter int POSW = 9,
    parameter int COLW = 5
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      line_start,
    input  logic                      ld_valid,
    output logic                      ld_ready,
    input  logic [POSW-1:0]           ld_posx,
    input  logic [31:0]               ld_pix,
    input  logic [3*COLW-1:0]         ld_pal,
    input  logic [3:0]                ld_scale,
    input  logic                      ld_mirror,
    input  logic [NSPR-1:0]           slot_mask,
    input  logic                      pix_en,
    input  logic [POSW-1:0]           cx,
    input  logic [COLW-1:0]           bcgcol,
    input  logic [1:0]                ui_sel,
    input  logic [3*COLW-1:0]         ui_pal,
    output logic [COLW-1:0]           out_col,
    output logic                      out_valid,
    output logic                      collision,
    output logic                      overflow,
    output logic [$clog2(NSPR+1)-1:0] ld_count
);

    localparam int CW = $clog2(NSPR+1);

    typedef enum logic {S_LOAD, S_DRAW} state_t;

    state_t            state_q;

    logic [POSW-1:0]   posx_q  [NSPR];
    logic [31:0]       pix_q   [NSPR];
    logic [3*COLW-1:0] pal_q   [NSPR];
    logic [3:0]        scale_q [NSPR];
    logic [3:0]        sub_q   [NSPR];
    logic [3:0]        idx_q   [NSPR];
    logic [NSPR-1:0]   mirror_q, valid_q, run_q, done_q;
    logic [CW-1:0]     ldCount_q;
    logic              overflow_q, collision_q;

    logic [1:0]        code1_q [NSPR];
    logic [1:0]        ui1_q;
    logic [COLW-1:0]   bcg1_q;
    logic              val1_q;
    logic [COLW-1:0]   outCol_q;
    logic              outValid_q;

    logic              loadAccept, loadSlot;
    logic [NSPR-1:0]   startS, activeS;
    logic [3:0]        curIdx [NSPR];
    logic [3:0]        curSub [NSPR];
    logic [1:0]        codeS  [NSPR];
    logic [COLW-1:0]   sprCol, finalCol;
    logic              anyOpq, multiOpq;

    // Palette lookup for codes 1..3; code 0 is transparent.
    function automatic logic [COLW-1:0] palEntry(input logic [3*COLW-1:0] pal,
                                                 input logic [1:0] c);
        case (c)
            2'd1:    return pal[COLW-1:0];
            2'd2:    return pal[2*COLW-1:COLW];
            2'd3:    return pal[3*COLW-1:2*COLW];
            default: return '0;
        endcase
    endfunction

    assign ld_ready   = (state_q == S_LOAD) & ~line_start;
    assign loadAccept = ld_valid & ld_ready;
    assign loadSlot   = loadAccept & (ldCount_q < CW'(NSPR));

    // Per-slot view of this cycle: whether the slot starts or is running,
    // and the code it shows. A starting slot shows idx 0 / sub 0. The bit
    // offset of pixel p is 30-2p; with mirror p=15-idx that is 2*idx, else
    // it is 2*(15-idx), i.e. the inverted index.
    always_comb begin
        for (int i = 0; i < NSPR; i++) begin
            startS[i]  = valid_q[i] & ~run_q[i] & ~done_q[i] & pix_en & (cx == posx_q[i]);
            activeS[i] = run_q[i] | startS[i];
            curIdx[i]  = startS[i] ? 4'd0 : idx_q[i];
            curSub[i]  = startS[i] ? 4'd0 : sub_q[i];
            codeS[i]   = pix_q[i][{(mirror_q[i] ? curIdx[i] : ~curIdx[i]), 1'b0} +: 2];
        end
    end

    // Two-state controller: line_start always wins and enters LOAD; the
    // first ordinary pixel moves to DRAW.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_DRAW;
        end else if (line_start) begin
            state_q <= S_LOAD;
        end else if (state_q == S_LOAD && pix_en) begin
            state_q <= S_DRAW;
        end
    end

    // Load count and overflow flag, both cleared per line.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ldCount_q  <= '0;
            overflow_q <= 1'b0;
        end else if (line_start) begin
            ldCount_q  <= '0;
            overflow_q <= 1'b0;
        end else if (loadSlot) begin
            ldCount_q  <= ldCount_q + CW'(1);
        end else if (loadAccept) begin
            overflow_q <= 1'b1;
        end
    end

    // Slot storage and pixel walkers. Slots fill in order, so the slot at
    // ld_count is always an invalid one when it is written.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q  <= '0;
            run_q    <= '0;
            done_q   <= '0;
            mirror_q <= '0;
            for (int i = 0; i < NSPR; i++) begin
                posx_q[i]  <= '0;
                pix_q[i]   <= '0;
                pal_q[i]   <= '0;
                scale_q[i] <= '0;
                sub_q[i]   <= '0;
                idx_q[i]   <= '0;
            end
        end else if (line_start) begin
            valid_q <= '0;
            run_q   <= '0;
            done_q  <= '0;
        end else begin
            for (int i = 0; i < NSPR; i++) begin
                if (loadSlot && ldCount_q == CW'(i)) begin
                    valid_q[i]  <= 1'b1;
                    run_q[i]    <= 1'b0;
                    done_q[i]   <= 1'b0;
                    posx_q[i]   <= ld_posx;
                    pix_q[i]    <= ld_pix;
                    pal_q[i]    <= ld_pal;
                    scale_q[i]  <= ld_scale;
                    mirror_q[i] <= ld_mirror;
                    sub_q[i]    <= '0;
                    idx_q[i]    <= '0;
                end else if (pix_en && activeS[i]) begin
                    if (curSub[i] == scale_q[i]) begin
                        sub_q[i] <= '0;
                        if (curIdx[i] == 4'd15) begin
                            run_q[i]  <= 1'b0;
                            done_q[i] <= 1'b1;
                        end else begin
                            idx_q[i] <= curIdx[i] + 4'd1;
                            run_q[i] <= 1'b1;
                        end
                    end else begin
                        sub_q[i] <= curSub[i] + 4'd1;
                        idx_q[i] <= curIdx[i];
                        run_q[i] <= 1'b1;
                    end
                end
            end
        end
    end

    // Stage 1: capture each slot's visible code with the live mask applied;
    // zero means transparent. A line_start pixel shows no sprites.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ui1_q  <= '0;
            bcg1_q <= '0;
            val1_q <= 1'b0;
            for (int i = 0; i < NSPR; i++) code1_q[i] <= '0;
        end else begin
            ui1_q  <= ui_sel;
            bcg1_q <= bcgcol;
            val1_q <= pix_en;
            for (int i = 0; i < NSPR; i++) begin
                code1_q[i] <= (pix_en & ~line_start & activeS[i] & slot_mask[i]) ? codeS[i] : 2'd0;
            end
        end
    end

    // Priority resolve: scanning high to low lets the lowest opaque slot win.
    always_comb begin
        sprCol   = bcg1_q;
        anyOpq   = 1'b0;
        multiOpq = 1'b0;
        for (int i = NSPR-1; i >= 0; i--) begin
            if (code1_q[i] != 2'd0) begin
                multiOpq = multiOpq | anyOpq;
                anyOpq   = 1'b1;
                sprCol   = palEntry(pal_q[i], code1_q[i]);
            end
        end
        finalCol = (ui1_q != 2'd0) ? palEntry(ui_pal, ui1_q) : sprCol;
    end

    // Stage 2: output registers and sticky collision flag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            outCol_q    <= '0;
            outValid_q  <= 1'b0;
            collision_q <= 1'b0;
        end else begin
            outCol_q   <= finalCol;
            outValid_q <= val1_q;
            if (line_start) begin
                collision_q <= 1'b0;
            end else if (multiOpq) begin
                collision_q <= 1'b1;
            end
        end
    end

    assign out_col   = outCol_q;
    assign out_valid = outValid_q;
    assign collision = collision_q;
    assign overflow  = overflow_q;
    assign ld_count  = ldCount_q;

endmodule

// File: tb/tb_sprite_line_engine.sv
// ---------------------------------------------------------------------------
// tb_sprite_line_engine
//
// Drives directed and random scanlines into sprite_line_engine and compares
// every cycle against a reference model that tracks each sprite as a count
// of displayed pixels, deriving the pixel index by division.
// ---------------------------------------------------------------------------
module tb_sprite_line_engine;

    localparam int NSPR = 8;
    localparam int POSW = 9;
    localparam int COLW = 5;
    localparam int CW   = $clog2(NSPR+1);

    logic              clk, rst, line_start, ld_valid, ld_ready, ld_mirror, pix_en;
    logic [POSW-1:0]   ld_posx, cx;
    logic [31:0]       ld_pix;
    logic [3*COLW-1:0] ld_pal, ui_pal;
    logic [3:0]        ld_scale;
    logic [NSPR-1:0]   slot_mask;
    logic [COLW-1:0]   bcgcol, out_col;
    logic [1:0]        ui_sel;
    logic              out_valid, collision, overflow;
    logic [CW-1:0]     ld_count;

    sprite_line_engine #(.NSPR(NSPR), .POSW(POSW), .COLW(COLW)) dut (
        .clk(clk), .rst(rst), .line_start(line_start), .ld_valid(ld_valid),
        .ld_ready(ld_ready), .ld_posx(ld_posx), .ld_pix(ld_pix), .ld_pal(ld_pal),
        .ld_scale(ld_scale), .ld_mirror(ld_mirror), .slot_mask(slot_mask),
        .pix_en(pix_en), .cx(cx), .bcgcol(bcgcol), .ui_sel(ui_sel), .ui_pal(ui_pal),
        .out_col(out_col), .out_valid(out_valid), .collision(collision),
        .overflow(overflow), .ld_count(ld_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit              v;
        logic [COLW-1:0] col;
        bit              multi;
        int              spot;
    } exp_t;

    exp_t            expQ[$];
    int              checks = 0;
    int              errors = 0;

    int              mNum, mCount;
    bit              mLoad, mOvf, mColl;
    int              mPosx   [NSPR];
    logic [31:0]     mPix    [NSPR];
    logic [14:0]     mPal    [NSPR];
    int              mScale  [NSPR];
    bit              mMirror [NSPR];
    int              mN      [NSPR];
    bit              mStarted[NSPR];
    int              spotCx  [4];
    int              spotCol [4];

    function automatic logic [COLW-1:0] palOf(input logic [3*COLW-1:0] pal, input int c);
        logic [3*COLW-1:0] sh;
        sh = pal >> ((c - 1) * COLW);
        return sh[COLW-1:0];
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic clearSpots();
        for (int s = 0; s < 4; s++) begin
            spotCx[s]  = -1;
            spotCol[s] = 0;
        end
    endtask

    task automatic modelReset();
        mNum = 0; mCount = 0; mLoad = 0; mOvf = 0; mColl = 0;
        expQ.delete();
        expQ.push_back('{v: 0, col: '0, multi: 0, spot: -1});
    endtask

    // Compare the registered outputs for the pixel two cycles back plus the
    // sticky flags and load count.
    task automatic checkOutput(input bit ls);
        exp_t e;
        e = expQ.pop_front();
        if (ls) mColl = 0;
        else if (e.multi) mColl = 1;
        check("out_valid", 32'(out_valid), 32'(e.v));
        if (e.v) check("out_col", 32'(out_col), 32'(e.col));
        if (e.v && e.spot >= 0) check("spot_col", 32'(out_col), 32'(e.spot));
        check("collision", 32'(collision), 32'(mColl));
        check("overflow", 32'(overflow), 32'(mOvf));
        check("ld_count", 32'(ld_count), 32'(mCount));
    endtask

    // One clock cycle with the inputs the caller has set up.
    task automatic applyStimulus();
        exp_t e;
        bit   ls;
        int   winner, wcode, nOpq, total, idx, p, code;
        @(negedge clk);
        check("ld_ready", 32'(ld_ready), 32'(mLoad && !line_start));
        ls = line_start;
        e = '{v: pix_en, col: bcgcol, multi: 0, spot: -1};
        if (pix_en) begin
            for (int s = 0; s < 4; s++) if (spotCx[s] == int'(cx)) e.spot = spotCol[s];
        end
        if (ls) begin
            if (ui_sel != 0) e.col = palOf(ui_pal, int'(ui_sel));
            mNum = 0; mCount = 0; mOvf = 0; mLoad = 1;
        end else begin
            if (pix_en) begin
                winner = -1; wcode = 0; nOpq = 0;
                for (int j = 0; j < mNum; j++) begin
                    total = 16 * (mScale[j] + 1);
                    if (!mStarted[j] && int'(cx) == mPosx[j]) mStarted[j] = 1;
                    if (mStarted[j] && mN[j] < total) begin
                        idx  = mN[j] / (mScale[j] + 1);
                        p    = mMirror[j] ? 15 - idx : idx;
                        code = int'((mPix[j] >> (30 - 2 * p)) & 32'd3);
                        mN[j]++;
                        if (code != 0 && slot_mask[j]) begin
                            nOpq++;
                            if (winner < 0) begin
                                winner = j;
                                wcode  = code;
                            end
                        end
                    end
                end
                if (ui_sel != 0)     e.col = palOf(ui_pal, int'(ui_sel));
                else if (winner >= 0) e.col = palOf(mPal[winner], wcode);
                e.multi = (nOpq >= 2);
            end
            if (mLoad && ld_valid) begin
                if (mCount < NSPR) begin
                    mPosx[mCount]    = int'(ld_posx);
                    mPix[mCount]     = ld_pix;
                    mPal[mCount]     = ld_pal;
                    mScale[mCount]   = int'(ld_scale);
                    mMirror[mCount]  = ld_mirror;
                    mN[mCount]       = 0;
                    mStarted[mCount] = 0;
                    mCount++;
                    mNum = mCount;
                end else begin
                    mOvf = 1;
                end
            end
            if (mLoad && pix_en) mLoad = 0;
        end
        expQ.push_back(e);
        @(posedge clk);
        #1;
        checkOutput(ls);
    endtask

    task automatic startLine();
        line_start = 1'b1;
        applyStimulus();
        line_start = 1'b0;
    endtask

    task automatic loadDesc(input int px, input logic [31:0] pix, input logic [14:0] pal,
                            input int scale, input bit mirror);
        ld_valid  = 1'b1;
        ld_posx   = POSW'(px);
        ld_pix    = pix;
        ld_pal    = pal;
        ld_scale  = 4'(scale);
        ld_mirror = mirror;
        applyStimulus();
        ld_valid  = 1'b0;
    endtask

    task automatic drawRun(input int from, input int to);
        for (int c = from; c <= to; c++) begin
            pix_en = 1'b1;
            cx     = POSW'(c);
            applyStimulus();
        end
        pix_en = 1'b0;
        applyStimulus();
        applyStimulus();
    endtask

    task automatic doReset();
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_col", 32'(out_col), 32'd0);
        check("rst_collision", 32'(collision), 32'd0);
        check("rst_overflow", 32'(overflow), 32'd0);
        check("rst_ld_count", 32'(ld_count), 32'd0);
        check("rst_ld_ready", 32'(ld_ready), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        pix_en = 1'b0; ld_valid = 1'b0; line_start = 1'b0;
        modelReset();
    endtask

    initial begin
        rst = 1'b1; line_start = 0; ld_valid = 0; ld_posx = '0; ld_pix = '0;
        ld_pal = '0; ld_scale = '0; ld_mirror = 0; slot_mask = '1; pix_en = 0;
        cx = '0; bcgcol = 5'd1; ui_sel = 2'd0; ui_pal = {5'd30, 5'd29, 5'd28};
        clearSpots();
        modelReset();
        doReset();

        $display("[TB] single sprite");
        startLine();
        loadDesc(10, 32'h4000_0003, {5'd7, 5'd6, 5'd5}, 0, 0);
        spotCx[0] = 10; spotCol[0] = 5;
        spotCx[1] = 25; spotCol[1] = 7;
        spotCx[2] = 11; spotCol[2] = 1;
        spotCx[3] = 26; spotCol[3] = 1;
        drawRun(0, 40);

        $display("[TB] scale and mirror");
        startLine();
        loadDesc(10, 32'h4000_0003, {5'd7, 5'd6, 5'd5}, 2, 1);
        spotCx[0] = 10; spotCol[0] = 7;
        spotCx[1] = 12; spotCol[1] = 7;
        spotCx[2] = 57; spotCol[2] = 5;
        spotCx[3] = 58; spotCol[3] = 1;
        drawRun(0, 70);

        $display("[TB] priority and collision");
        startLine();
        loadDesc(20, 32'h5555_5555, {5'd0, 5'd0, 5'd3}, 0, 0);
        loadDesc(24, 32'hFFFF_FFFF, {5'd9, 5'd0, 5'd0}, 0, 0);
        clearSpots();
        spotCx[0] = 30; spotCol[0] = 3;
        drawRun(0, 50);
        check("collision_set", 32'(collision), 32'd1);
        startLine();
        check("collision_clear", 32'(collision), 32'd0);
        slot_mask = 8'hFE;
        loadDesc(20, 32'h5555_5555, {5'd0, 5'd0, 5'd3}, 0, 0);
        loadDesc(24, 32'hFFFF_FFFF, {5'd9, 5'd0, 5'd0}, 0, 0);
        spotCol[0] = 9;
        drawRun(0, 50);
        check("collision_masked", 32'(collision), 32'd0);
        slot_mask = '1;

        $display("[TB] overflow");
        clearSpots();
        startLine();
        for (int k = 0; k < NSPR + 2; k++) begin
            loadDesc(5 + 12 * k, $urandom, 15'($urandom), 0, k[0]);
        end
        check("ovf_count", 32'(ld_count), 32'(NSPR));
        check("ovf_flag", 32'(overflow), 32'd1);
        drawRun(0, 140);

        $display("[TB] simultaneous events");
        startLine();
        line_start = 1'b1; ld_valid = 1'b1; pix_en = 1'b1; cx = POSW'(3);
        ld_posx = POSW'(3); ld_pix = '1; ld_pal = '1;
        spotCx[0] = 3; spotCol[0] = int'(bcgcol);
        applyStimulus();
        line_start = 1'b0; ld_valid = 1'b0; pix_en = 1'b0;
        applyStimulus();
        applyStimulus();
        check("simul_count", 32'(ld_count), 32'd0);
        clearSpots();
        loadDesc(8, 32'hFFFF_FFFF, {5'd15, 5'd14, 5'd13}, 1, 0);
        ui_sel = 2'd2;
        spotCx[0] = 12; spotCol[0] = 29;
        drawRun(0, 20);
        ui_sel = 2'd0;
        clearSpots();

        $display("[TB] random lines");
        for (int line = 0; line < 6; line++) begin
            int nLoads;
            startLine();
            nLoads = $urandom_range(0, NSPR + 2);
            for (int k = 0; k < nLoads; k++) begin
                if ($urandom_range(0, 3) == 0) applyStimulus();
                loadDesc($urandom_range(0, 60), $urandom, 15'($urandom),
                         $urandom_range(0, 3), 1'($urandom));
            end
            cx = '0;
            for (int k = 0; k < 150; k++) begin
                pix_en   = ($urandom_range(0, 3) != 0);
                ld_valid = ($urandom_range(0, 5) == 0);
                ld_posx  = POSW'($urandom_range(0, 60));
                ld_pix   = $urandom;
                if ($urandom_range(0, 19) == 0) slot_mask = NSPR'($urandom);
                ui_sel   = ($urandom_range(0, 7) == 0) ? 2'($urandom_range(1, 3)) : 2'd0;
                bcgcol   = COLW'($urandom);
                applyStimulus();
                if (pix_en) cx = cx + POSW'(1);
            end
            pix_en = 1'b0; ld_valid = 1'b0; ui_sel = 2'd0;
            applyStimulus();
            applyStimulus();
        end
        slot_mask = '1;
        bcgcol = 5'd2;

        $display("[TB] reset mid-sprite");
        startLine();
        loadDesc(5, 32'hFFFF_FFFF, {5'd20, 5'd21, 5'd22}, 3, 0);
        for (int c = 0; c <= 20; c++) begin
            pix_en = 1'b1;
            cx     = POSW'(c);
            applyStimulus();
        end
        doReset();
        spotCx[0] = 10; spotCol[0] = 2;
        drawRun(0, 80);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
